vreg_issue: RTL and testbench
=============================

# vreg_issue

Vector register file and issue sequencer that sits directly upstream of the registered vector add/sub stage `main`. It holds eight 4-lane × 8-bit vector registers, which are loaded one element at a time. It accepts one arithmetic instruction at a time and drives two source vectors plus the opcode into the add/sub stage. After that stage's fixed latency it captures the 4-lane result into the destination register.

## Interface
Parameters:
- `NREG`, 8: number of vector registers; register index width is 3.
- `LANES`, 4: elements per vector; fixed to 4 to match the add/sub stage.
- `EW`, 8: element width in bits.
- `ALU_LAT`, 2: clock edges from operand capture by the downstream stage to a stable result (input register plus output register).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load_valid`  in  1  element load request.
- `load_ready`  out  1  load accepted on an edge where `load_valid` and `load_ready` are both 1.
- `load_reg`  in  3  destination register of the load.
- `load_idx`  in  2  lane index, 0..3, of the load.
- `load_data`  in  EW  element value.
- `instr_valid`  in  1  instruction request.
- `instr_ready`  out  1  instruction accepted on an edge where `instr_valid` and `instr_ready` are both 1.
- `instr_op`  in  1  0 = add, 1 = subtract (src1 − src2).
- `instr_src1`, `instr_src2`, `instr_dst`  in  3 each  register indices.
- `out_vec1_1..4`, `out_vec2_1..4`  out  EW each  operands to the add/sub stage.
- `out_opcode`  out  1  opcode to the add/sub stage.
- `res_vec3_1..4`  in  EW each  results from the add/sub stage.
- `rd_reg`  in  3  read-port register index.
- `rd_idx`  in  2  read-port lane index.
- `rd_data`  out  EW  read-port data, registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `wb_done`  out  1  one-cycle pulse on the cycle after a writeback.

## Operation
- States: IDLE, WAIT, WB.
- IDLE:
  - `instr_ready` = 1.
  - `load_ready` = `!instr_valid`. An instruction has priority over a load; a load and an instruction are never both accepted on the same edge.
- Load acceptance: write `load_data` into `vreg[load_reg][load_idx]`.
- Instruction acceptance:
  - Read src1 and src2 from the register file contents before the edge.
  - Register the lanes onto `out_vec1_*` / `out_vec2_*` and `instr_op` onto `out_opcode`.
  - Latch `instr_dst` and clear the wait counter. Next state is WAIT.
  - src1, src2 and dst may be equal.
- WAIT:
  - `instr_ready` = 0 and `load_ready` = 0.
  - Increment the counter each cycle; when counter = `ALU_LAT`−1, next state is WB.
- WB:
  - On this edge, write `res_vec3_1..4` into `vreg[dst]` lanes 1..4, set `wb_done`, and move to IDLE.
  - `instr_ready` and `load_ready` stay 0 during WB.
- Operand and opcode outputs hold their values until the next instruction acceptance.
- Arithmetic is performed entirely downstream and wraps modulo 2^EW. This block never modifies the result data.
- Read port: `rd_data` <= `vreg[rd_reg][rd_idx]` every cycle, independent of state. A read of an element written on the same edge returns the old value.

## Timing
- Reset (`rst`=1 at an edge):
  - All `vreg` elements, operand outputs, `out_opcode`, `rd_data`, `wb_done` and the counter go to 0; state goes to IDLE.
  - `busy` = 0. `instr_ready` = 1; `load_ready` = `!instr_valid`.
- Reset mid-instruction (in WAIT or WB) aborts the instruction with no writeback and no `wb_done`.
- Instruction accepted at edge E0:
  - Operands are valid after E0; the downstream stage captures them at E1 and its result is stable after E2.
  - Writeback occurs at edge E0 + `ALU_LAT` + 1 (E3 for the default).
  - `wb_done` is high for the cycle following E3. The next instruction can be accepted at E4 at the earliest.
  - Sustained throughput is one instruction per `ALU_LAT`+2 cycles.
- A load can be accepted on every edge in IDLE while `instr_valid` = 0.
- Back-to-back dependent instructions are hazard-free because issue is fully serialized: the next instruction reads the written value.

## Structure
- Shared package `vreg_pkg`:
  - `NREG`, `LANES`, `EW`, `ALU_LAT` defaults.
  - `OP_ADD` = 0, `OP_SUB` = 1.
  - State enum (`S_IDLE`, `S_WAIT`, `S_WB`).
  - Register-index and lane-index typedefs.
- One natural sub-module, `vreg_bank`:
  - 8×4×EW storage.
  - One element write port (load) and one full-vector write port (writeback), which are mutually exclusive by construction.
  - Two full-vector combinational read ports and one element read port.
- `vreg_issue` contains the FSM, counter, handshakes and output registers.

## Test plan
- Reset check: assert `rst` for 2 cycles → every output is 0, `busy` = 0 and `instr_ready` = 1; `rd_data` of every element reads 0.
- Add: load v1 = {10,20,30,40} and v2 = {1,2,3,4}, issue add dst = v3 → v3 = {11,22,33,44}. Operand outputs are valid the cycle after acceptance, the writeback lands 3 edges after acceptance, and `wb_done` is a single pulse.
- Subtract with wrap: v1 = {0,5,255,128}, v2 = {1,5,1,129}, sub dst = v1 (dst equals src) → v1 = {255,0,254,255}.
- Priority and stall:
  - Assert `load_valid` and `instr_valid` together in IDLE → only the instruction is accepted; the load is taken on the first IDLE cycle after `wb_done`.
  - `load_valid` held through WAIT and WB → no write during those cycles.
- Dependent back-to-back: add v3 = v1 + v2, then immediately add v4 = v3 + v3 with `instr_valid` held high → the second instruction is accepted 4 edges after the first, and v4 = {22,44,66,88}.
- Reset mid-op: assert `rst` in WAIT → no writeback, v3 is unchanged at 0, `wb_done` is never asserted, and state returns to IDLE.

Source files
------------

// File: rtl/vreg_pkg.sv
// rtl/vreg_pkg.sv - shared defaults, opcodes, FSM states and index types for vreg_issue
package vreg_pkg;

   localparam int DEF_NREG    = 8;
   localparam int DEF_LANES   = 4;
   localparam int DEF_EW      = 8;
   localparam int DEF_ALU_LAT = 2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_WB
   } state_e;

   typedef logic [2:0] reg_idx_t;
   typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/vreg_bank.sv
// rtl/vreg_bank.sv - vector register storage: element load port, vector writeback port,
// two combinational vector read ports and one combinational element read port
module vreg_bank
   import vreg_pkg::*;
#(
   parameter int NREG  = DEF_NREG,
   parameter int LANES = DEF_LANES,
   parameter int EW    = DEF_EW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_we,
   input  reg_idx_t                   ld_reg,
   input  lane_idx_t                  ld_idx,
   input  logic [EW-1:0]              ld_data,
   input  logic                       wb_we,
   input  reg_idx_t                   wb_reg,
   input  logic [LANES-1:0][EW-1:0]   wb_vec,
   input  reg_idx_t                   ra_reg,
   output logic [LANES-1:0][EW-1:0]   ra_vec,
   input  reg_idx_t                   rb_reg,
   output logic [LANES-1:0][EW-1:0]   rb_vec,
   input  reg_idx_t                   re_reg,
   input  lane_idx_t                  re_idx,
   output logic [EW-1:0]              re_data
);

   logic [LANES-1:0][EW-1:0] mem_q [NREG];
   logic [LANES-1:0][EW-1:0] mem_d [NREG];

   // Load and writeback never coincide (the issuer only loads in IDLE), writeback wins anyway.
   always_comb begin
      mem_d = mem_q;
      if (wb_we) begin
         mem_d[wb_reg] = wb_vec;
      end else if (ld_we) begin
         mem_d[ld_reg][ld_idx] = ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign ra_vec  = mem_q[ra_reg];
   assign rb_vec  = mem_q[rb_reg];
   assign re_data = mem_q[re_reg][re_idx];

endmodule

// File: rtl/vreg_issue.sv
// rtl/vreg_issue.sv - vector register file front end: element loads, serialized issue
// to the registered add/sub stage and writeback of its result after a fixed latency
module vreg_issue
   import vreg_pkg::*;
#(
   parameter int NREG    = DEF_NREG,
   parameter int LANES   = DEF_LANES,
   parameter int EW      = DEF_EW,
   parameter int ALU_LAT = DEF_ALU_LAT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [2:0]    load_reg,
   input  logic [1:0]    load_idx,
   input  logic [EW-1:0] load_data,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic          instr_op,
   input  logic [2:0]    instr_src1,
   input  logic [2:0]    instr_src2,
   input  logic [2:0]    instr_dst,
   output logic [EW-1:0] out_vec1_1,
   output logic [EW-1:0] out_vec1_2,
   output logic [EW-1:0] out_vec1_3,
   output logic [EW-1:0] out_vec1_4,
   output logic [EW-1:0] out_vec2_1,
   output logic [EW-1:0] out_vec2_2,
   output logic [EW-1:0] out_vec2_3,
   output logic [EW-1:0] out_vec2_4,
   output logic          out_opcode,
   input  logic [EW-1:0] res_vec3_1,
   input  logic [EW-1:0] res_vec3_2,
   input  logic [EW-1:0] res_vec3_3,
   input  logic [EW-1:0] res_vec3_4,
   input  logic [2:0]    rd_reg,
   input  logic [1:0]    rd_idx,
   output logic [EW-1:0] rd_data,
   output logic          busy,
   output logic          wb_done
);

   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [LANES-1:0][EW-1:0] op1_q, op1_d;
   logic [LANES-1:0][EW-1:0] op2_q, op2_d;
   logic                     opcode_q, opcode_d;
   reg_idx_t                 dst_q, dst_d;
   logic [EW-1:0]            rd_data_q, rd_data_d;
   logic                     wb_done_q, wb_done_d;

   logic                     instr_fire;
   logic                     load_fire;
   logic                     wb_we;
   logic [LANES-1:0][EW-1:0] ra_vec;
   logic [LANES-1:0][EW-1:0] rb_vec;
   logic [LANES-1:0][EW-1:0] res_vec;
   logic [EW-1:0]            re_data;

   assign res_vec[0] = res_vec3_1;
   assign res_vec[1] = res_vec3_2;
   assign res_vec[2] = res_vec3_3;
   assign res_vec[3] = res_vec3_4;

   vreg_bank #(
      .NREG  (NREG),
      .LANES (LANES),
      .EW    (EW)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .ld_we   (load_fire),
      .ld_reg  (load_reg),
      .ld_idx  (load_idx),
      .ld_data (load_data),
      .wb_we   (wb_we),
      .wb_reg  (dst_q),
      .wb_vec  (res_vec),
      .ra_reg  (instr_src1),
      .ra_vec  (ra_vec),
      .rb_reg  (instr_src2),
      .rb_vec  (rb_vec),
      .re_reg  (rd_reg),
      .re_idx  (rd_idx),
      .re_data (re_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      opcode_d    = opcode_q;
      dst_d       = dst_q;
      rd_data_d   = re_data;
      wb_done_d   = 1'b0;
      wb_we       = 1'b0;
      instr_ready = 1'b0;
      load_ready  = 1'b0;
      instr_fire  = 1'b0;
      load_fire   = 1'b0;

      case (state_q)
         S_IDLE: begin
            instr_ready = 1'b1;
            load_ready  = !instr_valid;
            instr_fire  = instr_valid;
            load_fire   = load_valid && !instr_valid;
            if (instr_fire) begin
               op1_d    = ra_vec;
               op2_d    = rb_vec;
               opcode_d = instr_op;
               dst_d    = instr_dst;
               cnt_d    = '0;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(ALU_LAT - 1)) begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            wb_we     = 1'b1;
            wb_done_d = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         opcode_q  <= 1'b0;
         dst_q     <= '0;
         rd_data_q <= '0;
         wb_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         opcode_q  <= opcode_d;
         dst_q     <= dst_d;
         rd_data_q <= rd_data_d;
         wb_done_q <= wb_done_d;
      end
   end

   assign out_vec1_1 = op1_q[0];
   assign out_vec1_2 = op1_q[1];
   assign out_vec1_3 = op1_q[2];
   assign out_vec1_4 = op1_q[3];
   assign out_vec2_1 = op2_q[0];
   assign out_vec2_2 = op2_q[1];
   assign out_vec2_3 = op2_q[2];
   assign out_vec2_4 = op2_q[3];
   assign out_opcode = opcode_q;
   assign rd_data    = rd_data_q;
   assign wb_done    = wb_done_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_vreg_issue.sv
// tb/tb_vreg_issue.sv - directed bench for vreg_issue with a two-stage add/sub stage model
module tb_vreg_issue;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic [2:0] load_reg = '0;
   logic [1:0] load_idx = '0;
   logic [7:0] load_data = '0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic       instr_op = 1'b0;
   logic [2:0] instr_src1 = '0;
   logic [2:0] instr_src2 = '0;
   logic [2:0] instr_dst = '0;
   logic [7:0] out_vec1_1, out_vec1_2, out_vec1_3, out_vec1_4;
   logic [7:0] out_vec2_1, out_vec2_2, out_vec2_3, out_vec2_4;
   logic       out_opcode;
   logic [7:0] res_vec3_1, res_vec3_2, res_vec3_3, res_vec3_4;
   logic [2:0] rd_reg = '0;
   logic [1:0] rd_idx = '0;
   logic [7:0] rd_data;
   logic       busy;
   logic       wb_done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   vreg_issue dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_reg    (load_reg),
      .load_idx    (load_idx),
      .load_data   (load_data),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_op    (instr_op),
      .instr_src1  (instr_src1),
      .instr_src2  (instr_src2),
      .instr_dst   (instr_dst),
      .out_vec1_1  (out_vec1_1),
      .out_vec1_2  (out_vec1_2),
      .out_vec1_3  (out_vec1_3),
      .out_vec1_4  (out_vec1_4),
      .out_vec2_1  (out_vec2_1),
      .out_vec2_2  (out_vec2_2),
      .out_vec2_3  (out_vec2_3),
      .out_vec2_4  (out_vec2_4),
      .out_opcode  (out_opcode),
      .res_vec3_1  (res_vec3_1),
      .res_vec3_2  (res_vec3_2),
      .res_vec3_3  (res_vec3_3),
      .res_vec3_4  (res_vec3_4),
      .rd_reg      (rd_reg),
      .rd_idx      (rd_idx),
      .rd_data     (rd_data),
      .busy        (busy),
      .wb_done     (wb_done)
   );

   // Downstream add/sub stage: operand register, then result register.
   logic [7:0] m_a [4] = '{default: 8'd0};
   logic [7:0] m_b [4] = '{default: 8'd0};
   logic [7:0] m_r [4] = '{default: 8'd0};
   logic       m_op = 1'b0;

   always @(posedge clk) begin
      m_a[0] <= out_vec1_1;
      m_a[1] <= out_vec1_2;
      m_a[2] <= out_vec1_3;
      m_a[3] <= out_vec1_4;
      m_b[0] <= out_vec2_1;
      m_b[1] <= out_vec2_2;
      m_b[2] <= out_vec2_3;
      m_b[3] <= out_vec2_4;
      m_op   <= out_opcode;
      for (int i = 0; i < 4; i++) begin
         m_r[i] <= m_op ? (m_a[i] - m_b[i]) : (m_a[i] + m_b[i]);
      end
   end

   assign res_vec3_1 = m_r[0];
   assign res_vec3_2 = m_r[1];
   assign res_vec3_3 = m_r[2];
   assign res_vec3_4 = m_r[3];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_elem(input logic [2:0] r, input logic [1:0] idx, input logic [7:0] d);
      load_valid = 1'b1;
      load_reg   = r;
      load_idx   = idx;
      load_data  = d;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic load_vec(input logic [2:0] r, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
      load_elem(r, 2'd0, e0);
      load_elem(r, 2'd1, e1);
      load_elem(r, 2'd2, e2);
      load_elem(r, 2'd3, e3);
   endtask

   task automatic read_elem(input logic [2:0] r, input logic [1:0] idx, output logic [7:0] d);
      rd_reg = r;
      rd_idx = idx;
      tick();
      d = rd_data;
   endtask

   task automatic drive_instr(input logic op, input logic [2:0] s1, input logic [2:0] s2,
                              input logic [2:0] dst);
      instr_valid = 1'b1;
      instr_op    = op;
      instr_src1  = s1;
      instr_src2  = s2;
      instr_dst   = dst;
   endtask

   // Returns the number of edges until wb_done is seen, or -1 on timeout.
   task automatic wait_wb(output int n);
      n = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (wb_done === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst = 1'b1;
      tick();
      tick();
      tests++;
      if ({out_vec1_1, out_vec1_2, out_vec1_3, out_vec1_4,
           out_vec2_1, out_vec2_2, out_vec2_3, out_vec2_4} !== 64'd0) begin
         fails++;
         $display("FAIL reset_operands: got %h want 0", {out_vec1_1, out_vec1_2, out_vec1_3,
                  out_vec1_4, out_vec2_1, out_vec2_2, out_vec2_3, out_vec2_4});
      end
      tests++;
      if ({out_opcode, wb_done, busy, instr_ready, load_ready, rd_data} !== {5'b00011, 8'd0}) begin
         fails++;
         $display("FAIL reset_ctrl: got op=%b wb=%b busy=%b ir=%b lr=%b rd=%h want 0,0,0,1,1,00",
                  out_opcode, wb_done, busy, instr_ready, load_ready, rd_data);
      end
      instr_valid = 1'b1;
      #1;
      tests++;
      if (load_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_load_ready_prio: got %b want 0", load_ready);
      end
      instr_valid = 1'b0;
      tick();
      rst = 1'b0;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 4; i++) begin
            read_elem(3'(r), 2'(i), d);
            tests++;
            if (d !== 8'd0) begin
               fails++;
               $display("FAIL reset_vreg[%0d][%0d]: got %0d want 0", r, i, d);
            end
         end
      end
   endtask

   task automatic test_add();
      logic [7:0] d;
      logic [7:0] exp_v3 [4];
      exp_v3 = '{8'd11, 8'd22, 8'd33, 8'd44};
      load_vec(3'd1, 8'd10, 8'd20, 8'd30, 8'd40);
      load_vec(3'd2, 8'd1, 8'd2, 8'd3, 8'd4);
      rd_reg = 3'd3;
      rd_idx = 2'd0;
      drive_instr(1'b0, 3'd1, 3'd2, 3'd3);
      tick();
      instr_valid = 1'b0;
      tests++;
      if ({out_vec1_1, out_vec1_2, out_vec1_3, out_vec1_4} !== {8'd10, 8'd20, 8'd30, 8'd40}
          || {out_vec2_1, out_vec2_2, out_vec2_3, out_vec2_4} !== {8'd1, 8'd2, 8'd3, 8'd4}
          || out_opcode !== 1'b0) begin
         fails++;
         $display("FAIL add_operands: got v1=%h v2=%h op=%b want 0a141e28 01020304 0",
                  {out_vec1_1, out_vec1_2, out_vec1_3, out_vec1_4},
                  {out_vec2_1, out_vec2_2, out_vec2_3, out_vec2_4}, out_opcode);
      end
      tests++;
      if (busy !== 1'b1 || instr_ready !== 1'b0 || load_ready !== 1'b0) begin
         fails++;
         $display("FAIL add_busy_e0: got busy=%b ir=%b lr=%b want 1,0,0", busy, instr_ready, load_ready);
      end
      tick();
      tick();
      tests++;
      if (wb_done !== 1'b0) begin
         fails++;
         $display("FAIL add_wb_early: got wb_done=%b after E2 want 0", wb_done);
      end
      tick();
      tests++;
      if (wb_done !== 1'b1 || busy !== 1'b0 || rd_data !== 8'd0) begin
         fails++;
         $display("FAIL add_wb_e3: got wb=%b busy=%b rd=%0d want 1,0,0", wb_done, busy, rd_data);
      end
      tick();
      tests++;
      if (wb_done !== 1'b0 || rd_data !== 8'd11) begin
         fails++;
         $display("FAIL add_wb_pulse: got wb=%b rd=%0d want 0,11", wb_done, rd_data);
      end
      for (int i = 0; i < 4; i++) begin
         read_elem(3'd3, 2'(i), d);
         tests++;
         if (d !== exp_v3[i]) begin
            fails++;
            $display("FAIL add_v3[%0d]: got %0d want %0d", i, d, exp_v3[i]);
         end
      end
   endtask

   task automatic test_sub_wrap();
      logic [7:0] d;
      int n;
      logic [7:0] exp_v1 [4];
      exp_v1 = '{8'd255, 8'd0, 8'd254, 8'd255};
      load_vec(3'd1, 8'd0, 8'd5, 8'd255, 8'd128);
      load_vec(3'd2, 8'd1, 8'd5, 8'd1, 8'd129);
      drive_instr(1'b1, 3'd1, 3'd2, 3'd1);
      tick();
      instr_valid = 1'b0;
      tests++;
      if (out_opcode !== 1'b1) begin
         fails++;
         $display("FAIL sub_opcode: got %b want 1", out_opcode);
      end
      wait_wb(n);
      tests++;
      if (n != 3) begin
         fails++;
         $display("FAIL sub_wb_latency: got %0d edges want 3", n);
      end
      for (int i = 0; i < 4; i++) begin
         read_elem(3'd1, 2'(i), d);
         tests++;
         if (d !== exp_v1[i]) begin
            fails++;
            $display("FAIL sub_v1[%0d]: got %0d want %0d", i, d, exp_v1[i]);
         end
      end
   endtask

   task automatic test_priority();
      logic [7:0] d;
      logic [7:0] exp_v6 [4];
      exp_v6 = '{8'd0, 8'd5, 8'd255, 8'd128};
      rd_reg     = 3'd5;
      rd_idx     = 2'd0;
      load_valid = 1'b1;
      load_reg   = 3'd5;
      load_idx   = 2'd0;
      load_data  = 8'd77;
      drive_instr(1'b0, 3'd1, 3'd2, 3'd6);
      #1;
      tests++;
      if (load_ready !== 1'b0 || instr_ready !== 1'b1) begin
         fails++;
         $display("FAIL prio_ready: got lr=%b ir=%b want 0,1", load_ready, instr_ready);
      end
      tick();
      instr_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (load_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_load_ready[%0d]: got %b want 0", k, load_ready);
         end
         tick();
      end
      tests++;
      if (wb_done !== 1'b1 || load_ready !== 1'b1 || rd_data !== 8'd0) begin
         fails++;
         $display("FAIL stall_no_write: got wb=%b lr=%b rd=%0d want 1,1,0", wb_done, load_ready, rd_data);
      end
      tick();
      load_valid = 1'b0;
      tests++;
      if (rd_data !== 8'd0) begin
         fails++;
         $display("FAIL stall_same_edge_read: got %0d want 0", rd_data);
      end
      tick();
      tests++;
      if (rd_data !== 8'd77) begin
         fails++;
         $display("FAIL stall_load_taken: got %0d want 77", rd_data);
      end
      for (int i = 0; i < 4; i++) begin
         read_elem(3'd6, 2'(i), d);
         tests++;
         if (d !== exp_v6[i]) begin
            fails++;
            $display("FAIL prio_v6[%0d]: got %0d want %0d", i, d, exp_v6[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      int acc;
      int n;
      logic [7:0] exp_v4 [4];
      exp_v4 = '{8'd22, 8'd44, 8'd66, 8'd88};
      load_vec(3'd1, 8'd10, 8'd20, 8'd30, 8'd40);
      load_vec(3'd2, 8'd1, 8'd2, 8'd3, 8'd4);
      load_vec(3'd3, 8'd0, 8'd0, 8'd0, 8'd0);
      drive_instr(1'b0, 3'd1, 3'd2, 3'd3);
      tick();
      drive_instr(1'b0, 3'd3, 3'd3, 3'd4);
      acc = -1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (instr_ready === 1'b1) begin
            acc = k + 1;
            break;
         end
      end
      tests++;
      if (acc != 4) begin
         fails++;
         $display("FAIL b2b_accept_edge: got %0d want 4", acc);
      end
      tick();
      instr_valid = 1'b0;
      wait_wb(n);
      tests++;
      if (n != 3) begin
         fails++;
         $display("FAIL b2b_wb_latency: got %0d want 3", n);
      end
      for (int i = 0; i < 4; i++) begin
         read_elem(3'd4, 2'(i), d);
         tests++;
         if (d !== exp_v4[i]) begin
            fails++;
            $display("FAIL b2b_v4[%0d]: got %0d want %0d", i, d, exp_v4[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      int seen;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      load_vec(3'd1, 8'd10, 8'd20, 8'd30, 8'd40);
      load_vec(3'd2, 8'd1, 8'd2, 8'd3, 8'd4);
      drive_instr(1'b0, 3'd1, 3'd2, 3'd3);
      tick();
      instr_valid = 1'b0;
      tick();
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL mid_busy_wait: got %b want 1", busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (busy !== 1'b0 || instr_ready !== 1'b1 || out_vec1_1 !== 8'd0) begin
         fails++;
         $display("FAIL mid_reset_state: got busy=%b ir=%b v1_1=%0d want 0,1,0", busy, instr_ready, out_vec1_1);
      end
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (wb_done !== 1'b0) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL mid_wb_done: got %0d pulses want 0", seen);
      end
      for (int i = 0; i < 4; i++) begin
         read_elem(3'd3, 2'(i), d);
         tests++;
         if (d !== 8'd0) begin
            fails++;
            $display("FAIL mid_v3[%0d]: got %0d want 0", i, d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_wrap();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
